ram_banked_param: RTL and testbench
===================================

// Module: ram_banked_param
// PURPOSE
//  Parametrised single-port synchronous RAM. Successor to the fixed 16x32 two-bank RAM.
//  Storage is split into NBANK banks; the address MSBs select the bank.
//  Adds a registered read with an out_valid strobe, a ready handshake, and a hardware clear engine.
//  The clear engine zeroes every word after reset and on request.
//  Used as CPU data/register storage behind the datapath mux.
// PARAMETERS
//  WIDTH  32  data word width, bits (>=1)
//  DEPTH  16  total words; power of two, >= NBANK
//  NBANK  2   number of banks; power of two, divides DEPTH
// PORTS
//  clk      in   1                 clock; all state updates on posedge
//  rst_n    in   1                 reset, asynchronous, active-low
//  en       in   1                 access request; accepted only when en && ready
//  read     in   1                 1 = read, 0 = write (sampled with en)
//  address  in   log2(DEPTH)       word address; MSBs = bank, LSBs = row
//  in       in   WIDTH             write data
//  clear    in   1                 pulse: restart full memory clear
//  out      out  WIDTH             read data, registered
//  out_valid out 1                 1-cycle strobe: out holds new read data
//  ready    out  1                 1 = block accepts an access this cycle
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - out=0, out_valid=0, ready=0.
//    - FSM enters CLEAR with row counter=0.
//    - The array itself is not reset; it is zeroed by the clear engine.
//  - FSM states:
//    - CLEAR: each cycle writes 0 to row `cnt` of ALL banks in parallel, then cnt++.
//      When cnt == DEPTH/NBANK-1, the next state is IDLE.
//      Clear therefore takes DEPTH/NBANK cycles; ready=0 throughout.
//    - IDLE: ready=1. A clear pulse moves the FSM to CLEAR with cnt=0 on the next edge.
//  - Write (IDLE, en=1, read=0): mem[bank][row] <= in at the edge. out and out_valid unchanged.
//  - Read (IDLE, en=1, read=1): out <= mem[bank][row] at the edge; out_valid=1 for that one cycle.
//    Latency is 1 clock. out holds its value until the next accepted read.
//  - en while ready=0: ignored; no write, no read, no error flag.
//  - Bank select: only the addressed bank's write enable fires. No other bank is modified.
//  - Output mux: out is taken from the addressed bank only (registered select, not an OR of banks).
//  - Simultaneous IDLE access and clear:
//    - The access completes normally, including the read strobe.
//    - CLEAR starts on the following cycle and overwrites the written word.
//  - clear during CLEAR: restarts from cnt=0.
//  - out_valid forced 0 in CLEAR. out keeps its last value (not zeroed by clear).
//  - Reset mid-clear or mid-access: immediate return to the reset state; clear reruns fully.
//  - Address wrap: not applicable. Full-range addresses are all legal; no out-of-range case.
//  - Width rules: row = address[log2(DEPTH/NBANK)-1:0]; bank = the upper log2(NBANK) bits.
//    NBANK=1 means no bank bits.
// STRUCTURE
//  - Shared include ram_defs.vh:
//    - clog2 function.
//    - FSM state encodings ST_IDLE/ST_CLEAR.
//    - Default WIDTH/DEPTH/NBANK constants.
//  - Sub-module ram_bank_cell:
//    - One bank: (DEPTH/NBANK) x WIDTH array, one write port, one combinational read port.
//    - Instantiated NBANK times via generate.
//  - Top level holds: FSM, clear counter, bank decode, write-data/enable mux (clear vs user),
//    output register and out_valid.
// TESTING
//  1. Reset, defaults:
//     - Release rst_n -> ready=0 for exactly 8 cycles, then 1.
//     - Reading every address then returns 0.
//  2. Write/read:
//     - Write 0xDEADBEEF @3, 0x12345678 @11.
//     - Read @3 -> out=0xDEADBEEF one cycle later with out_valid=1; read @11 -> 0x12345678.
//     - Verify no cross-bank aliasing: @3 must not read 0x12345678.
//  3. Access blocked during clear:
//     - Pulse clear, then write 0xA5A5A5A5 @5 while ready=0.
//     - After ready rises, read @5 -> 0.
//  4. Simultaneous events:
//     - Write 0x1 @2 in the same cycle as clear -> write occurs, then ready=0 for 8 cycles.
//     - Read @2 afterwards -> 0.
//  5. Reset mid-clear:
//     - Assert rst_n=0 at clear cycle 4 -> out=0 and out_valid=0 immediately.
//     - After release, ready stays 0 for a full 8 cycles.
//  6. Parameter sweep:
//     - WIDTH=8, DEPTH=64, NBANK=4 -> clear takes 16 cycles.
//     - Write addr k with data k for all 64 words; read back all 64 with 1-cycle latency.

Source files
------------

// File: rtl/ram_banked_param_pkg.sv
// Shared constants and helpers for the banked RAM: default geometry,
// FSM state encodings and a constant-foldable ceil(log2) helper.
package ram_banked_param_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_NBANK = 2;

  // state   | meaning
  // IDLE    | ready=1, user accesses accepted
  // CLEAR   | zeroing one row of every bank per cycle, ready=0
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // ceil(log2(v)); used only on elaboration-time constants
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_banked_param_bank_cell.sv
// One storage bank: ROWS x WIDTH words, single write port and a
// combinational read port sharing the same row address.
module ram_banked_param_bank_cell #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 8,
  parameter int RW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [RW-1:0]    row,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [ROWS];

  // storage write; the array has no reset, the clear engine zeroes it
  always_ff @(posedge clk) begin
    if (we) r_mem[row] <= wdata;
  end

  assign rdata = r_mem[row];

endmodule

// File: rtl/ram_banked_param.sv
// Banked single-port RAM with registered read, ready handshake and a
// clear engine that zeroes all banks in parallel, one row per cycle.
module ram_banked_param
  import ram_banked_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NBANK = DEF_NBANK,
  localparam int AW   = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             read,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] in,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             ready
);

  localparam int ROWS = DEPTH / NBANK;
  localparam int RW   = (ROWS > 1) ? clog2(ROWS) : 1;
  localparam int BW   = (NBANK > 1) ? clog2(NBANK) : 1;

  logic [0:0]       r_state;
  logic [RW-1:0]    r_cnt;
  logic [RW-1:0]    w_row;
  logic [BW-1:0]    w_bank;
  logic             w_clearing;
  logic             w_acc;
  logic             w_wr;
  logic             w_rd;
  logic [RW-1:0]    w_cell_row;
  logic [WIDTH-1:0] w_cell_wdata;
  logic [WIDTH-1:0] w_rdata [NBANK];

  // address split: low bits pick the row, the remaining MSBs pick the bank
  generate
    if (ROWS > 1) begin : g_row
      assign w_row = address[RW-1:0];
    end else begin : g_row1
      assign w_row = '0;
    end
    if (NBANK > 1) begin : g_bank_sel
      assign w_bank = address[AW-1:AW-BW];
    end else begin : g_bank_sel1
      assign w_bank = '0;
    end
  endgenerate

  assign w_clearing   = (r_state == ST_CLEAR);
  assign ready        = ~w_clearing;
  assign w_acc        = en & ~w_clearing;
  assign w_wr         = w_acc & ~read;
  assign w_rd         = w_acc & read;
  assign w_cell_row   = w_clearing ? r_cnt : w_row;
  assign w_cell_wdata = w_clearing ? '0 : in;

  // clear writes every bank at once; a user write only hits its own bank
  generate
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
      ram_banked_param_bank_cell #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS),
        .RW    (RW)
      ) u_cell (
        .clk   (clk),
        .we    (w_clearing | (w_wr & (w_bank == BW'(b)))),
        .row   (w_cell_row),
        .wdata (w_cell_wdata),
        .rdata (w_rdata[b])
      );
    end
  endgenerate

  // clear sequencing: restart on a clear pulse, leave after the last row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (clear) begin
            r_cnt <= '0;
          end else if (r_cnt == RW'(ROWS - 1)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // registered read from the addressed bank only; out holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_rd;
      if (w_rd) out <= w_rdata[w_bank];
    end
  end

endmodule

// File: tb/tb_ram_banked_param.sv
// Bench for ram_banked_param: a default instance (32x16, 2 banks) and a
// swept instance (8x64, 4 banks), both compared each cycle against a
// word-array model plus directed literal checks.
module tb_ram_banked_param;

  logic            clk;
  logic            rst_n;
  logic [1:0]      en_i, rd_i, clr_i;
  logic [1:0][5:0] addr_i;
  logic [1:0][31:0] din_i;
  logic [31:0]     out_a;
  logic [7:0]      out_b;
  logic [1:0]      val_o, rdy_o;

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 0;

  ram_banked_param dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_i[0]), .read(rd_i[0]),
    .address(addr_i[0][3:0]), .in(din_i[0]), .clear(clr_i[0]),
    .out(out_a), .out_valid(val_o[0]), .ready(rdy_o[0])
  );

  ram_banked_param #(.WIDTH(8), .DEPTH(64), .NBANK(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_i[1]), .read(rd_i[1]),
    .address(addr_i[1]), .in(din_i[1][7:0]), .clear(clr_i[1]),
    .out(out_b), .out_valid(val_o[1]), .ready(rdy_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int depth_of(int k);
    return (k == 1) ? 64 : 16;
  endfunction
  function automatic int rows_of(int k);
    return (k == 1) ? 16 : 8;
  endfunction
  function automatic logic [31:0] mask_of(int k);
    return (k == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] dut_out(int k);
    return (k == 1) ? {24'b0, out_b} : out_a;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: memory as a flat word array; a clear makes the whole memory
  // zero and blocks access for rows_of(k) cycles.
  logic [31:0] m_mem [2][64];
  logic [31:0] m_out [2];
  logic        m_val [2];
  int          m_busy [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_out[k] = '0;
        m_val[k] = 1'b0;
        m_busy[k] = rows_of(k);
        for (int i = 0; i < 64; i++) m_mem[k][i] = '0;
      end else begin
        m_val[k] = 1'b0;
        if (m_busy[k] == 0 && en_i[k]) begin
          if (rd_i[k]) begin
            m_out[k] = m_mem[k][addr_i[k]];
            m_val[k] = 1'b1;
          end else begin
            m_mem[k][addr_i[k]] = din_i[k] & mask_of(k);
          end
        end
        if (clr_i[k]) begin
          m_busy[k] = rows_of(k);
          for (int i = 0; i < 64; i++) m_mem[k][i] = '0;
        end else if (m_busy[k] > 0) begin
          m_busy[k] = m_busy[k] - 1;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ready[%0d]", k), {31'b0, rdy_o[k]}, {31'b0, m_busy[k] == 0});
        chk($sformatf("out_valid[%0d]", k), {31'b0, val_o[k]}, {31'b0, m_val[k]});
        chk($sformatf("out[%0d]", k), dut_out(k), m_out[k]);
      end
    end
  end

  task automatic access(int k, bit r, int a, logic [31:0] d);
    en_i[k] = 1'b1;
    rd_i[k] = r;
    addr_i[k] = 6'(a);
    din_i[k] = d;
    @(negedge clk);
    en_i[k] = 1'b0;
    rd_i[k] = 1'b0;
  endtask

  task automatic rd_chk(int k, int a, logic [31:0] exp, string nm);
    access(k, 1'b1, a, 32'h0);
    chk({nm, "_valid"}, {31'b0, val_o[k]}, 32'h1);
    chk(nm, dut_out(k), exp);
  endtask

  task automatic busy_len(int k, output int n);
    n = 0;
    while (!rdy_o[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int na, nb, n;
    rst_n = 1'b0;
    en_i = '0; rd_i = '0; clr_i = '0; addr_i = '0; din_i = '0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_out", out_a, 32'h0);
    chk("rst_ready", {31'b0, rdy_o[0]}, 32'h0);

    // 1. clear length after reset release, then every word reads 0
    rst_n = 1'b1;
    n = 0; na = -1; nb = -1;
    while ((na < 0 || nb < 0) && n < 200) begin
      @(negedge clk);
      n++;
      if (na < 0 && rdy_o[0]) na = n;
      if (nb < 0 && rdy_o[1]) nb = n;
    end
    chk("clr_cycles_a", na, 8);
    chk("clr_cycles_b", nb, 16);
    for (int a = 0; a < 16; a++) rd_chk(0, a, 32'h0, "rd_zero");

    // 2. write/read, no aliasing between banks
    access(0, 1'b0, 3, 32'hDEADBEEF);
    access(0, 1'b0, 11, 32'h12345678);
    rd_chk(0, 3, 32'hDEADBEEF, "rd3");
    rd_chk(0, 11, 32'h12345678, "rd11");
    rd_chk(0, 3, 32'hDEADBEEF, "rd3_alias");
    @(negedge clk);
    chk("out_hold", out_a, 32'hDEADBEEF);
    chk("valid_strobe", {31'b0, val_o[0]}, 32'h0);

    // 3. write during clear is ignored
    clr_i[0] = 1'b1;
    @(negedge clk);
    clr_i[0] = 1'b0;
    access(0, 1'b0, 5, 32'hA5A5A5A5);
    busy_len(0, n);
    chk("clr_wait3", {31'b0, rdy_o[0]}, 32'h1);
    rd_chk(0, 5, 32'h0, "rd5_blocked");

    // 4. write coincident with clear: write lands, then full clear
    en_i[0] = 1'b1; rd_i[0] = 1'b0; addr_i[0] = 6'd2; din_i[0] = 32'h1; clr_i[0] = 1'b1;
    @(negedge clk);
    en_i[0] = 1'b0; clr_i[0] = 1'b0;
    busy_len(0, n);
    chk("clr_cycles_sim", n, 8);
    rd_chk(0, 2, 32'h0, "rd2_after_clr");

    // 5. reset in the middle of a clear
    access(0, 1'b0, 1, 32'hCAFE0001);
    rd_chk(0, 1, 32'hCAFE0001, "rd1");
    clr_i[0] = 1'b1;
    @(negedge clk);
    clr_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", out_a, 32'h0);
    chk("midrst_valid", {31'b0, val_o[0]}, 32'h0);
    chk("midrst_ready", {31'b0, rdy_o[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_len(0, n);
    chk("clr_cycles_rst", n, 8);
    busy_len(1, n);
    chk("clr_wait_b", {31'b0, rdy_o[1]}, 32'h1);

    // 6. swept geometry: fill with address, read back
    for (int a = 0; a < 64; a++) access(1, 1'b0, a, 32'(a));
    for (int a = 0; a < 64; a++) rd_chk(1, a, 32'(a), "sweep_rd");

    // randomized traffic with occasional clears on both instances
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        en_i[k] = ($urandom % 4) != 0;
        rd_i[k] = $urandom % 2;
        addr_i[k] = 6'($urandom_range(depth_of(k) - 1));
        din_i[k] = $urandom;
        clr_i[k] = ($urandom % 60) == 0;
      end
      @(negedge clk);
    end
    en_i = '0; rd_i = '0; clr_i = '0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
